rf_port_ctrl: RTL and testbench

Controller that sits between the pipeline and the 32x32 register file and owns its write port (a3/wd3/we3) and read port 1 (a1/rd1). After reset it clears x1..x31 to zero. It then shares the write port between the writeback stage and a debug/loader requester, with writeback always taking priority. Debug reads borrow read port 1 for one stalled cycle.

---
 rtl/rf_port_ctrl.sv | 158 +++++++++++++++
 tb/tb_rf_port_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_port_ctrl.sv
// Register-file port controller: clears x1..x(NREGS-1) after reset, then arbitrates the write port (writeback > clear > debug) and lends read port 1 to debug reads.
// Latency: rf_* outputs are combinational; debug read/write acks two cycles after the request is sampled in IDLE (plus one per contended writeback cycle).
// Backpressure: writeback is never blocked; a debug write waits behind writeback and raises stall once it has waited STARVE_LIMIT cycles.
//
// Ports:
//   i_clk, i_reset                    clock, asynchronous active-high reset
//   i_wb_we/i_wb_addr/i_wb_data       writeback write request (highest priority)
//   i_dec_a1                          decode-stage read address for port 1
//   i_dbg_req/i_dbg_wr/i_dbg_addr/i_dbg_wdata   debug request, held until o_dbg_ack
//   o_dbg_ack, o_dbg_rdata            one-cycle completion pulse, read data (held until the next read)
//   o_rf_we3/o_rf_a3/o_rf_wd3         regfile write port
//   o_rf_a1, i_rf_rd1                 regfile read port 1
//   o_stall, o_init_done              pipeline freeze, clear sequence finished
module rf_port_ctrl #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter int CLEAR_ON_RESET = 1,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [4:0]      i_dec_a1,
  input  logic            i_dbg_req,
  input  logic            i_dbg_wr,
  input  logic [4:0]      i_dbg_addr,
  input  logic [XLEN-1:0] i_dbg_wdata,
  output logic            o_dbg_ack,
  output logic [XLEN-1:0] o_dbg_rdata,
  output logic            o_rf_we3,
  output logic [4:0]      o_rf_a3,
  output logic [XLEN-1:0] o_rf_wd3,
  output logic [4:0]      o_rf_a1,
  input  logic [XLEN-1:0] i_rf_rd1,
  output logic            o_stall,
  output logic            o_init_done
);

  localparam int            WW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [4:0]    LAST    = 5'(NREGS - 1);
  localparam logic [WW-1:0] LIMIT   = WW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_DBG_RD,
    S_DBG_WR,
    S_ACK
  } state_t;

  state_t          r_state;
  logic [4:0]      r_clr_cnt;
  logic [WW-1:0]   r_wait_cnt;
  logic            r_dbg_ack;
  logic [XLEN-1:0] r_dbg_rdata;
  logic            r_init_done;

  logic w_wb_win;
  logic w_clr_win;
  logic w_dbg_win;

  // Write-port arbitration. Writes to x0 are filtered at every source so the
  // port never presents we3 with address 0.
  assign w_wb_win  = i_wb_we && (i_wb_addr != 5'd0);
  assign w_clr_win = !w_wb_win && (r_state == S_CLEAR);
  assign w_dbg_win = !w_wb_win && (r_state == S_DBG_WR) && (i_dbg_addr != 5'd0);

  always_comb begin
    o_rf_we3 = 1'b0;
    o_rf_a3  = 5'd0;
    o_rf_wd3 = '0;
    if (w_wb_win) begin
      o_rf_we3 = 1'b1;
      o_rf_a3  = i_wb_addr;
      o_rf_wd3 = i_wb_data;
    end else if (w_clr_win) begin
      o_rf_we3 = 1'b1;
      o_rf_a3  = r_clr_cnt;
    end else if (w_dbg_win) begin
      o_rf_we3 = 1'b1;
      o_rf_a3  = i_dbg_addr;
      o_rf_wd3 = i_dbg_wdata;
    end
  end

  assign o_rf_a1 = (r_state == S_DBG_RD) ? i_dbg_addr : i_dec_a1;

  // Stall during clear and the borrowed read cycle; a debug write only stalls
  // the pipeline once it has been starved long enough for writeback to drain.
  always_comb begin
    o_stall = 1'b0;
    case (r_state)
      S_CLEAR:  o_stall = 1'b1;
      S_DBG_RD: o_stall = 1'b1;
      S_DBG_WR: o_stall = (r_wait_cnt >= LIMIT);
      default:  o_stall = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      r_clr_cnt   <= 5'd1;
      r_wait_cnt  <= '0;
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= '0;
      r_init_done <= (CLEAR_ON_RESET == 0);
    end else begin
      case (r_state)
        S_CLEAR: begin
          // The clear pointer only advances when its write actually landed.
          if (w_clr_win) begin
            if (r_clr_cnt == LAST) begin
              r_state     <= S_IDLE;
              r_init_done <= 1'b1;
            end else begin
              r_clr_cnt <= r_clr_cnt + 5'd1;
            end
          end
        end
        S_IDLE: begin
          if (i_dbg_req) begin
            r_state <= i_dbg_wr ? S_DBG_WR : S_DBG_RD;
          end
        end
        S_DBG_RD: begin
          r_dbg_rdata <= (i_dbg_addr == 5'd0) ? '0 : i_rf_rd1;
          r_dbg_ack   <= 1'b1;
          r_state     <= S_ACK;
        end
        S_DBG_WR: begin
          if (w_dbg_win || (i_dbg_addr == 5'd0)) begin
            r_state    <= S_ACK;
            r_dbg_ack  <= 1'b1;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt < LIMIT) begin
            r_wait_cnt <= r_wait_cnt + WAIT_ONE;
          end
        end
        S_ACK: begin
          r_dbg_ack <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_dbg_ack   = r_dbg_ack;
  assign o_dbg_rdata = r_dbg_rdata;
  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_rf_port_ctrl.sv
// Bench for rf_port_ctrl: drives a negedge-writing register-file model and checks the controller cycle by cycle.
// Latency: outputs sampled 4 time units after each posedge, before the regfile negedge write.
// Backpressure: debug requests are held until the ack is seen, as the requester protocol demands.
module tb_rf_port_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic [4:0]  dec_a1 = 5'd0;
  logic        dbg_req = 1'b0;
  logic        dbg_wr = 1'b0;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_wdata = 32'd0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        rf_we3;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [4:0]  rf_a1;
  logic [31:0] rf_rd1;
  logic        stall;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_port_ctrl #(.XLEN(32), .NREGS(32), .CLEAR_ON_RESET(1), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_dec_a1(dec_a1),
    .i_dbg_req(dbg_req), .i_dbg_wr(dbg_wr), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata),
    .o_rf_we3(rf_we3), .o_rf_a3(rf_a3), .o_rf_wd3(rf_wd3),
    .o_rf_a1(rf_a1), .i_rf_rd1(rf_rd1),
    .o_stall(stall), .o_init_done(init_done)
  );

  // Register-file model: writes on negedge; x0 reads back garbage so the
  // controller's own zero-forcing for debug reads is visible.
  logic [31:0] rf [32];
  logic        junk_req = 1'b0;
  logic        x0_wr = 1'b0;
  int          ack_cnt = 0;

  assign rf_rd1 = (rf_a1 == 5'd0) ? 32'hBAD0_0000 : rf[rf_a1];

  always @(negedge clk) begin
    if (junk_req) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (rf_we3) begin
      rf[rf_a3] <= rf_wd3;
      if (rf_a3 == 5'd0) x0_wr <= 1'b1;
    end
    if (dbg_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  // Leaves time at posedge+1 of clear cycle 1, with the regfile filled with junk.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    junk_req = 1'b1;
    @(negedge clk);
    #1;
    junk_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  dec_a1;
    logic        exp_we3;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd3;
    logic [4:0]  exp_a1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int ack_base;

    vecs[0] = '{1'b1, 5'd5,  32'h0000_0011, 5'd3,  1'b1, 5'd5,  32'h0000_0011, 5'd3};
    vecs[1] = '{1'b1, 5'd0,  32'h0000_0022, 5'd4,  1'b0, 5'd0,  32'h0,         5'd4};
    vecs[2] = '{1'b0, 5'd6,  32'h0000_0033, 5'd31, 1'b0, 5'd0,  32'h0,         5'd31};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd0,  1'b1, 5'd31, 32'hFFFF_FFFF, 5'd0};
    vecs[4] = '{1'b1, 5'd1,  32'h0000_0000, 5'd17, 1'b1, 5'd1,  32'h0,         5'd17};
    vecs[5] = '{1'b0, 5'd0,  32'h0000_0000, 5'd9,  1'b0, 5'd0,  32'h0,         5'd9};

    // Reset state and full clear with no writeback traffic.
    do_reset();
    chk("reset_ack", dbg_ack, 0);
    chk("reset_rdata", dbg_rdata, 0);
    for (int i = 1; i <= 31; i++) begin
      smp();
      chk("clr_we3", rf_we3, 1);
      chk("clr_a3", rf_a3, i);
      chk("clr_wd3", rf_wd3, 0);
      chk("clr_stall", stall, 1);
      chk("clr_init_low", init_done, 0);
      step();
    end
    smp();
    chk("clr_init_done", init_done, 1);
    chk("clr_stall_drop", stall, 0);
    chk("clr_idle_we3", rf_we3, 0);
    for (int i = 1; i <= 31; i++) chk("clr_reg_zero", rf[i], 0);
    step();

    // Clear interrupted by a writeback to x5 while the clear pointer is at 3.
    do_reset();
    for (int c = 1; c <= 2; c++) begin
      smp();
      chk("int_a3", rf_a3, c);
      step();
    end
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
    smp();
    chk("int_wb_we3", rf_we3, 1);
    chk("int_wb_a3", rf_a3, 5);
    chk("int_wb_wd3", rf_wd3, 32'h1234);
    chk("int_wb_stall", stall, 1);
    step();
    wb_we = 1'b0;
    for (int c = 4; c <= 32; c++) begin
      smp();
      chk("int_clr_a3", rf_a3, c - 1);
      chk("int_init_low", init_done, 0);
      step();
    end
    smp();
    chk("int_init_done", init_done, 1);
    chk("int_x3", rf[3], 0);
    chk("int_x5", rf[5], 0);
    step();

    // Writeback mux and read-port address in IDLE.
    foreach (vecs[k]) begin
      wb_we = vecs[k].wb_we; wb_addr = vecs[k].wb_addr;
      wb_data = vecs[k].wb_data; dec_a1 = vecs[k].dec_a1;
      smp();
      chk("vec_we3", rf_we3, vecs[k].exp_we3);
      if (vecs[k].exp_we3) begin
        chk("vec_a3", rf_a3, vecs[k].exp_a3);
        chk("vec_wd3", rf_wd3, vecs[k].exp_wd3);
      end
      chk("vec_a1", rf_a1, vecs[k].exp_a1);
      chk("vec_stall", stall, 0);
      step();
    end
    wb_we = 1'b0;
    dec_a1 = 5'd2;

    // Uncontended debug write of x7, then read it back.
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'hDEAD_BEEF;
    smp();
    chk("dw_idle_stall", stall, 0);
    chk("dw_idle_ack", dbg_ack, 0);
    step();
    smp();
    chk("dw_we3", rf_we3, 1);
    chk("dw_a3", rf_a3, 7);
    chk("dw_wd3", rf_wd3, 32'hDEAD_BEEF);
    chk("dw_stall", stall, 0);
    chk("dw_ack_early", dbg_ack, 0);
    step();
    dbg_req = 1'b0;
    smp();
    chk("dw_ack", dbg_ack, 1);
    step();
    smp();
    chk("dw_ack_drop", dbg_ack, 0);
    chk("dw_x7", rf[7], 32'hDEAD_BEEF);

    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd7;
    smp();
    chk("dr_idle_stall", stall, 0);
    chk("dr_idle_a1", rf_a1, 2);
    step();
    smp();
    chk("dr_stall", stall, 1);
    chk("dr_a1", rf_a1, 7);
    step();
    dbg_req = 1'b0;
    smp();
    chk("dr_ack", dbg_ack, 1);
    chk("dr_rdata", dbg_rdata, 32'hDEAD_BEEF);
    chk("dr_ack_stall", stall, 0);
    step();
    smp();
    chk("dr_ack_drop", dbg_ack, 0);
    chk("dr_rdata_hold", dbg_rdata, 32'hDEAD_BEEF);
    step();

    // Debug write to x9 contended by six writeback cycles to x12.
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h0000_0099;
    smp();
    step();
    wb_we = 1'b1; wb_addr = 5'd12;
    for (int k = 1; k <= 6; k++) begin
      wb_data = 32'h0000_1000 + 32'(k);
      smp();
      chk("starve_stall", stall, (k >= 5) ? 1 : 0);
      chk("starve_a3", rf_a3, 12);
      chk("starve_ack", dbg_ack, 0);
      step();
    end
    wb_we = 1'b0;
    smp();
    chk("starve_commit_we3", rf_we3, 1);
    chk("starve_commit_a3", rf_a3, 9);
    chk("starve_commit_wd3", rf_wd3, 32'h99);
    chk("starve_commit_stall", stall, 1);
    step();
    dbg_req = 1'b0;
    smp();
    chk("starve_ack", dbg_ack, 1);
    chk("starve_ack_stall", stall, 0);
    step();
    chk("starve_x9", rf[9], 32'h99);
    chk("starve_x12", rf[12], 32'h1006);

    // Debug read and write of x0.
    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd0;
    smp();
    step();
    smp();
    chk("x0r_stall", stall, 1);
    chk("x0r_a1", rf_a1, 0);
    step();
    dbg_req = 1'b0;
    smp();
    chk("x0r_ack", dbg_ack, 1);
    chk("x0r_rdata", dbg_rdata, 0);
    step();
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'h55;
    smp();
    step();
    smp();
    chk("x0w_we3", rf_we3, 0);
    step();
    dbg_req = 1'b0;
    smp();
    chk("x0w_ack", dbg_ack, 1);
    step();

    // Reset in the middle of a starved debug write to x9.
    ack_base = ack_cnt;
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h77;
    wb_we = 1'b1; wb_addr = 5'd12; wb_data = 32'h2000;
    smp();
    step();
    smp();
    chk("rst_wr_a3", rf_a3, 12);
    step();
    smp();
    step();
    reset = 1'b1; dbg_req = 1'b0; wb_we = 1'b0;
    smp();
    chk("rst_stall", stall, 1);
    chk("rst_ack", dbg_ack, 0);
    chk("rst_init", init_done, 0);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      smp();
      chk("rst_clr_a3", rf_a3, i);
      step();
    end
    smp();
    chk("rst_init_done", init_done, 1);
    chk("rst_x9", rf[9], 0);
    chk("rst_no_ack", ack_cnt - ack_base, 0);
    chk("x0_never_written", x0_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
